imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 144 ++++++++++++++
 tb/tb_imem_loader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loader that frames, checksums and writes 32-bit words into instruction memory.
// Frame: A5, count lo, count hi, 4*count little-endian data bytes, XOR checksum byte.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM, RESP} state_t;

  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [ADDR_W:0] widx_q, widx_d;
  logic [1:0]    lane_q, lane_d;
  logic [23:0]   word_q, word_d;
  logic [7:0]    xor_q, xor_d;
  logic          pass_q, pass_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;

  logic          accept;
  logic [15:0]   count_rx;
  logic          last_word;

  assign in_ready  = (state_q != RESP);
  assign accept    = in_valid && in_ready;
  assign count_rx  = {in_data, cnt_q[7:0]};
  assign last_word = (16'(widx_q) == (cnt_q - 16'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      widx_q  <= '0;
      lane_q  <= '0;
      word_q  <= '0;
      xor_q   <= '0;
      pass_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      xor_q   <= xor_d;
      pass_q  <= pass_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    lane_d  = lane_q;
    word_d  = word_q;
    xor_d   = xor_q;
    pass_d  = pass_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    case (state_q)
      IDLE: begin
        if (accept && in_data == 8'hA5) begin
          state_d = LEN_LO;
          widx_d  = '0;
          lane_d  = '0;
          word_d  = '0;
          xor_d   = '0;
        end
      end
      LEN_LO: begin
        if (accept) begin
          cnt_d   = {8'h00, in_data};
          state_d = LEN_HI;
        end
      end
      LEN_HI: begin
        if (accept) begin
          cnt_d = count_rx;
          // Out-of-range lengths skip straight to the response without touching memory.
          if (count_rx == 16'd0 || {1'b0, count_rx} > MAX_WORDS) begin
            pass_d  = 1'b0;
            state_d = RESP;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          xor_d  = xor_q ^ in_data;
          lane_d = lane_q + 2'd1;
          case (lane_q)
            2'd0: word_d[7:0]   = in_data;
            2'd1: word_d[15:8]  = in_data;
            2'd2: word_d[23:16] = in_data;
            default: begin
              we_d    = 1'b1;
              wdata_d = {in_data, word_q};
              addr_d  = 32'({widx_q[ADDR_W-1:0], 2'b00});
              widx_d  = widx_q + 1'b1;
              if (last_word) state_d = CSUM;
            end
          endcase
        end
      end
      CSUM: begin
        if (accept) begin
          pass_d  = (in_data == xor_q);
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_hold  = (state_q != IDLE);
  assign done      = (state_q == RESP) && pass_q;
  assign err       = (state_q == RESP) && !pass_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader: directed frames, monitor pops expected writes/pulses.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  imem_loader #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  localparam int K_WR = 0, K_DONE = 1, K_ERR = 2;
  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic exp_push(input int kind, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.kind = kind; e.addr = a; e.data = d;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input int kind);
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected event: kind %0d addr 0x%08h data 0x%08h with empty scoreboard", kind, mem_addr, mem_wdata);
    end else begin
      e = sb.pop_front();
      chk("event kind", 32'(kind), 32'(e.kind));
      if (kind == K_WR) begin
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_wdata", mem_wdata, e.data);
      end else begin
        chk("cpu_hold during RESP", {31'd0, cpu_hold}, 32'd1);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (mem_we) pop_chk(K_WR);
      if (done)   pop_chk(K_DONE);
      if (err)    pop_chk(K_ERR);
    end
  end

  task automatic send(input logic [7:0] b, output int waits);
    waits = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && waits < 8) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send timeout: in_ready=%0b expected 1 for byte 0x%02h", in_ready, b);
    end
    @(posedge clk);
  endtask

  task automatic sendb(input logic [7:0] b);
    int w;
    send(b, w);
  endtask

  // in_data carries a sync byte while invalid so an ignored-invalid bug would show.
  task automatic gap(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'hA5;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic send_seq(input logic [7:0] q[$], input bit gaps);
    foreach (q[i]) begin
      sendb(q[i]);
      if (gaps && i >= 3 && (i % 2) == 0) gap(1 + int'($urandom_range(0, 2)));
    end
  endtask

  // Two-word program; XOR checksum = 13^00^10^00^93^00^20^00 = B0.
  task automatic nominal(input logic [7:0] csum, input bit gaps);
    logic [7:0] f[$];
    f = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00, csum};
    exp_push(K_WR, 32'h0, 32'h0010_0013);
    exp_push(K_WR, 32'h4, 32'h0020_0093);
    exp_push(csum == 8'hB0 ? K_DONE : K_ERR, 32'h0, 32'h0);
    send_seq(f, gaps);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] f[$];
    int w;

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #12;
    chk("reset mem_we", {31'd0, mem_we}, 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset err", {31'd0, err}, 32'd0);
    chk("reset cpu_hold", {31'd0, cpu_hold}, 32'd0);
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Nominal load, with cpu_hold checked after sync and after completion.
    exp_push(K_WR, 32'h0, 32'h0010_0013);
    exp_push(K_WR, 32'h4, 32'h0020_0093);
    exp_push(K_DONE, 32'h0, 32'h0);
    sendb(8'hA5);
    #1 chk("cpu_hold after sync", {31'd0, cpu_hold}, 32'd1);
    f = {8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00, 8'hB0};
    send_seq(f, 1'b0);
    gap(3);
    chk("cpu_hold back in IDLE", {31'd0, cpu_hold}, 32'd0);

    // Bad checksum: both writes still happen, then err.
    nominal(8'hB1, 1'b0);
    gap(2);

    // Length errors: zero words and 257 words.
    exp_push(K_ERR, 32'h0, 32'h0);
    f = {8'hA5, 8'h00, 8'h00};
    send_seq(f, 1'b0);
    exp_push(K_ERR, 32'h0, 32'h0);
    f = {8'hA5, 8'h01, 8'h01};
    send_seq(f, 1'b0);
    gap(2);

    // Noise before sync, then gapped frame.
    f = {8'h00, 8'hFF, 8'h5A};
    send_seq(f, 1'b0);
    chk("cpu_hold after noise", {31'd0, cpu_hold}, 32'd0);
    nominal(8'hB0, 1'b1);

    // Byte held valid across RESP: one stall cycle, then accepted as a new sync.
    nominal(8'hB0, 1'b0);
    send(8'hA5, w);
    chk("RESP stall cycles", 32'(w), 32'd1);
    exp_push(K_ERR, 32'h0, 32'h0);
    f = {8'h00, 8'h00};
    send_seq(f, 1'b0);
    gap(2);

    // Maximum length: 256 words, word i = four copies of i, checksum 00.
    f = {8'hA5, 8'h00, 8'h01};
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 4; j++) f.push_back(8'(i));
      exp_push(K_WR, 32'(i * 4), {4{8'(i)}});
    end
    f.push_back(8'h00);
    exp_push(K_DONE, 32'h0, 32'h0);
    send_seq(f, 1'b0);
    gap(2);

    // Reset after two data bytes, then a clean load from address 0.
    f = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00};
    send_seq(f, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midframe reset mem_we", {31'd0, mem_we}, 32'd0);
    chk("midframe reset mem_wdata", mem_wdata, 32'd0);
    chk("midframe reset mem_addr", mem_addr, 32'd0);
    chk("midframe reset cpu_hold", {31'd0, cpu_hold}, 32'd0);
    chk("midframe reset done/err", {30'd0, done, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nominal(8'hB0, 1'b0);

    gap(6);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
